// File: rtl/uart_rx.sv
// 8N1 serial receiver: 2-flop sync, mid-bit 3-sample majority vote; byte offered 9*DIV+H+2 clocks after start-edge detect.
// Single-entry valid/ready holding register: a byte arriving while it is full and not being consumed is dropped and flags overrun.
module uart_rx #(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       brk,
    output logic       overrun,
    output logic       busy
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int H  = DIV / 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(H);
    localparam logic [CW-1:0] CNT_S2   = CW'(H + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

    state_e          state_q, state_d;
    logic            rx_meta_q, rx_s_q, rx_d_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bitidx_q, bitidx_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      smp_q, smp_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;
    logic            brk_q, brk_d;

    logic start_edge, at_last, at_stop, vote_full, vote_stop, consume;
    logic cnt_run, shift_en, byte_ok, byte_bad, load, drop;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign start_edge = rx_d_q & ~rx_s_q;
    assign at_last    = (cnt_q == CNT_LAST);
    assign at_stop    = (cnt_q == CNT_S2);
    assign vote_full  = maj3(smp_q[0], smp_q[1], smp_q[2]);
    // STOP is judged at H+1, so the third sample is the live synchronised line.
    assign vote_stop  = maj3(smp_q[0], smp_q[1], rx_s_q);
    assign consume    = valid_q & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!ena) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_edge) state_d = START;
                START:   if (at_last) state_d = vote_full ? IDLE : DATA;
                DATA:    if (at_last && bitidx_q == 3'd7) state_d = STOP;
                STOP:    if (at_stop) state_d = (!vote_stop && shift_q == 8'h00) ? BREAK : IDLE;
                BREAK:   if (rx_s_q) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state_q != IDLE);
        cnt_run  = 1'b0;
        shift_en = 1'b0;
        byte_ok  = 1'b0;
        byte_bad = 1'b0;
        if (ena) begin
            case (state_q)
                START:   cnt_run = 1'b1;
                DATA: begin
                    cnt_run  = 1'b1;
                    shift_en = at_last;
                end
                STOP: begin
                    cnt_run  = 1'b1;
                    byte_ok  = at_stop & vote_stop;
                    byte_bad = at_stop & ~vote_stop;
                end
                default: cnt_run = 1'b0;
            endcase
        end
        load = byte_ok & (~valid_q | ready);
        drop = byte_ok & valid_q & ~ready;
    end

    always_comb begin
        cnt_d = (cnt_run && !at_last && state_d == state_q) ? cnt_q + CW'(1) : '0;

        bitidx_d = '0;
        if (ena && state_q == DATA) bitidx_d = at_last ? bitidx_q + 3'd1 : bitidx_q;

        shift_d = shift_q;
        if (shift_en) shift_d[bitidx_q] = vote_full;

        smp_d = smp_q;
        if (cnt_run) begin
            if (cnt_q == CNT_S0) smp_d[0] = rx_s_q;
            if (cnt_q == CNT_S1) smp_d[1] = rx_s_q;
            if (cnt_q == CNT_S2) smp_d[2] = rx_s_q;
        end

        // A byte loading on the consumption edge wins over the clear.
        data_d  = load ? shift_q : data_q;
        valid_d = load ? 1'b1 : (consume ? 1'b0 : valid_q);

        overrun_d = drop ? 1'b1 : (consume ? 1'b0 : overrun_q);

        frame_err_d = byte_bad;
        brk_d       = (state_d == BREAK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_d_q      <= 1'b1;
            cnt_q       <= '0;
            bitidx_q    <= '0;
            shift_q     <= '0;
            smp_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            rx_d_q      <= rx_s_q;
            cnt_q       <= cnt_d;
            bitidx_q    <= bitidx_d;
            shift_q     <= shift_d;
            smp_q       <= smp_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            brk_q       <= brk_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign brk       = brk_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: the line driver pushes each expected byte and its valid-rise cycle,
// a negedge monitor checks accepted bytes, rise timing and frame_err pulses; directed cases cover the flag paths.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int DIV = 16;
    localparam int H   = DIV / 2;
    // Cycles from driving the start bit (just after a posedge) until valid is visible.
    localparam int LAT = 9 * DIV + H + 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, brk, overrun, busy;

    uart_rx #(.DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx),
        .data(data), .valid(valid), .ready(ready),
        .frame_err(frame_err), .brk(brk), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] exp_data_q[$];
    int         exp_rise_q[$];
    int         nvec = 0, nerr = 0;
    int         fe_exp = 0, fe_seen = 0;
    logic       valid_prev = 1'b0, fe_prev = 1'b0;
    logic [7:0] last_good = 8'h00;
    int         mon_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            valid_prev = 1'b0;
            fe_prev    = 1'b0;
        end else begin
            if (valid && !valid_prev) begin
                nvec++;
                if (exp_rise_q.size() == 0) begin
                    nerr++;
                    $display("FAIL valid_rise: unexpected byte 0x%0h at cycle %0d", data, cyc);
                end else begin
                    mon_t = exp_rise_q.pop_front();
                    if (cyc < mon_t - 1 || cyc > mon_t + 1) begin
                        nerr++;
                        $display("FAIL valid_latency: rose at cycle %0d, expected %0d +-1", cyc, mon_t);
                    end
                end
            end
            if (valid && ready) begin
                if (exp_data_q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL rx_byte: accepted 0x%0h with nothing expected (cycle %0d)", data, cyc);
                end else begin
                    chk("rx_byte", 32'(data), 32'(exp_data_q.pop_front()));
                end
            end
            if (frame_err) begin
                fe_seen++;
                chk("frame_err_width", 32'(fe_prev), 32'h0);
            end
            valid_prev = valid;
            fe_prev    = frame_err;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame; glitch_bit>=0 flips that data bit for a single clock near mid-bit.
    task automatic send(input logic [7:0] b, input logic stop, input int glitch_bit, input bit expect_byte);
        tick(1);
        if (expect_byte) begin
            exp_data_q.push_back(b);
            exp_rise_q.push_back(cyc + LAT);
            last_good = b;
        end
        if (!stop) fe_exp++;
        rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == glitch_bit) begin
                tick(H);
                rx = ~b[i];
                tick(1);
                rx = b[i];
                tick(DIV - H - 1);
            end else begin
                tick(DIV);
            end
        end
        rx = stop;
        tick(DIV);
        rx = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        int         mode;

        // Reset values
        tick(3);
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_brk", 32'(brk), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        ena   = 1'b1;
        tick(5);

        // Basic byte
        send(8'hA5, 1'b1, -1, 1'b1);
        tick(DIV);
        chk("a5_busy_idle", 32'(busy), 32'h0);
        chk("a5_overrun", 32'(overrun), 32'h0);

        // Random frames: clean, glitched and bad-stop
        for (int k = 0; k < 24; k++) begin
            b    = 8'($urandom);
            mode = $urandom_range(0, 3);
            if (mode == 0)      send(b | 8'h01, 1'b0, -1, 1'b0);
            else if (mode == 1) send(b, 1'b1, $urandom_range(0, 7), 1'b1);
            else                send(b, 1'b1, -1, 1'b1);
            tick($urandom_range(1, 2 * DIV));
        end
        tick(DIV);
        chk("rand_fe_count", 32'(fe_seen), 32'(fe_exp));

        // False start
        tick(1);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        chk("fs_busy_start", 32'(busy), 32'h1);
        tick(DIV + 2);
        chk("fs_busy_idle", 32'(busy), 32'h0);
        chk("fs_fe_count", 32'(fe_seen), 32'(fe_exp));

        // Framing error, byte discarded
        send(8'h3C, 1'b0, -1, 1'b0);
        tick(DIV);
        chk("fe_valid", 32'(valid), 32'h0);
        chk("fe_data_kept", 32'(data), 32'(last_good));
        chk("fe_count", 32'(fe_seen), 32'(fe_exp));

        // Break: line low for 20 bit times
        tick(1);
        rx = 1'b0;
        fe_exp++;
        tick(20 * DIV);
        chk("brk_high", 32'(brk), 32'h1);
        chk("brk_busy", 32'(busy), 32'h1);
        chk("brk_fe_count", 32'(fe_seen), 32'(fe_exp));
        rx = 1'b1;
        tick(2);
        chk("brk_hold_until_sync", 32'(brk), 32'h1);
        tick(1);
        chk("brk_release", 32'(brk), 32'h0);
        tick(DIV);
        send(8'h55, 1'b1, -1, 1'b1);
        tick(DIV);

        // Overrun with a stalled consumer
        ready = 1'b0;
        send(8'h11, 1'b1, -1, 1'b1);
        tick(2);
        send(8'h22, 1'b1, -1, 1'b0);
        tick(DIV);
        chk("ovr_data", 32'(data), 32'h11);
        chk("ovr_valid", 32'(valid), 32'h1);
        chk("ovr_flag", 32'(overrun), 32'h1);
        ready = 1'b1;
        tick(1);
        chk("ovr_valid_clr", 32'(valid), 32'h0);
        chk("ovr_flag_clr", 32'(overrun), 32'h0);

        // Single-clock glitch inside a '1' bit
        tick(DIV);
        send(8'hFF, 1'b1, 3, 1'b1);
        tick(DIV);
        chk("glitch_data", 32'(data), 32'hFF);

        // ena dropped mid-frame aborts without output
        tick(1);
        rx = 1'b0;
        tick(3 * DIV);
        ena = 1'b0;
        tick(1);
        chk("ena_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        tick(10 * DIV);
        ena = 1'b1;
        tick(DIV);
        chk("ena_data_kept", 32'(data), 32'hFF);

        // Reset mid-frame with a byte held
        ready = 1'b0;
        send(8'h5A, 1'b1, -1, 1'b1);
        tick(2);
        rx = 1'b0;
        tick(DIV);
        rx = 1'b1;
        tick(DIV);
        rx = 1'b0;
        tick(2 * DIV + 3);
        rst_n = 1'b0;
        tick(1);
        exp_data_q.delete();
        chk("mid_rst_data", 32'(data), 32'h0);
        chk("mid_rst_valid", 32'(valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_overrun", 32'(overrun), 32'h0);
        rx    = 1'b1;
        ready = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(12 * DIV);
        chk("post_rst_valid", 32'(valid), 32'h0);
        chk("post_rst_frame_err_count", 32'(fe_seen), 32'(fe_exp));

        chk("bytes_outstanding", 32'(exp_data_q.size()), 32'h0);
        chk("rises_outstanding", 32'(exp_rise_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver: 8N1 format, LSB first, idle-high line. It is the receive-side counterpart of the hub's uart_tx and uses the same clocks-per-bit divisor (DIV=434 gives 115200 baud at 50 MHz).
- Synchronises the rx pin and validates the start bit. Each bit is recovered by a 3-sample majority vote at mid-bit.
- Received bytes are presented on a single-entry valid/ready holding register, with framing-error, break and overrun reporting.
- Sits between a ui_in pin and downstream command/config logic.

Parameters:
- DIV, 434, clock cycles per bit; legal range 8..65535. H = DIV/2 (integer division) is the mid-bit count.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- ena  input  1  block enable; 0 aborts any frame in progress and holds the FSM in IDLE
- rx  input  1  serial line, asynchronous to clk, idle high
- data  output  8  last accepted byte
- valid  output  1  data holds an unconsumed byte
- ready  input  1  consumer accepts data when valid && ready
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- brk  output  1  high while a break condition persists
- overrun  output  1  sticky: a byte was dropped because the holding register was full
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset values: data=0x00, valid=0, frame_err=0, brk=0, overrun=0, busy=0. Both synchroniser flops reset to 1. FSM=IDLE, counters=0.
- rx passes through a 2-flop synchroniser to give rx_s. A registered copy rx_d provides falling-edge detection.
- Bit timer cnt runs 0..DIV-1 within each bit period. The samples at cnt = H-1, H and H+1 are majority-voted; the result is used at the evaluation point below.
- IDLE: when rx_s==0 and rx_d==1, go to START with cnt=0. A line that is already low never triggers a start (no edge).
- START: at cnt==DIV-1, if the vote is 1 (false start) return to IDLE with no outputs affected. Otherwise go to DATA with bitidx=0, cnt=0.
- DATA: at cnt==DIV-1, shift the vote into shift[bitidx] (LSB first). After bitidx==7, go to STOP with cnt=0.
- STOP: evaluate at cnt==H+1, ending the frame early to resync on back-to-back frames. The state exits on that edge.
  - Vote=1 and (valid==0, or valid && ready in the same cycle): data<=shift, valid<=1 on that edge; go to IDLE.
  - Vote=1 and valid==1 and ready==0: drop the byte, overrun<=1, data/valid unchanged; go to IDLE.
  - Vote=0 and shift!=0x00: frame_err pulses for 1 cycle; byte discarded; go to IDLE.
  - Vote=0 and shift==0x00: frame_err pulses for 1 cycle, brk<=1; go to BREAK.
- BREAK: hold brk=1 until rx_s==1, then brk<=0 and go to IDLE. No start can be detected while in BREAK.
- Consumption: on valid && ready, valid<=0 next cycle unless a new byte loads on the same edge (new byte wins, valid stays 1). overrun clears on the same consumption edge.
- ena=0: FSM<=IDLE, cnt/bitidx cleared, no byte or flag generated. data, valid and overrun are held; consumption still works.
- busy=1 in START, DATA, STOP and BREAK.
- Latency: the falling edge of rx is seen in rx_s after 2 clocks, with a further 1 clock for edge detection. valid then rises exactly 9*DIV + H + 2 cycles after the edge-detect cycle. The bench allows +-1 cycle only for rx phase relative to clk.
- Reset mid-frame: everything returns to reset values immediately; any partial byte is lost.

Test Plan:
- DIV=16: send 0xA5 (8N1) with ready=1 -> one valid pulse with data=0xA5, frame_err=0, overrun=0, busy low after STOP.
- rx low for 4 clocks, then high -> false start: no valid, no frame_err, FSM back in IDLE within DIV cycles.
- Send 0x3C with the stop bit driven low -> frame_err single-cycle pulse, valid stays 0, data unchanged.
- rx held low for 20 bit times -> frame_err pulse then brk=1 until rx returns high; brk=0 the cycle after rx_s=1; then 0x55 is received correctly.
- ready=0: send 0x11 then 0x22 -> data=0x11 valid=1 overrun=1. Assert ready -> valid=0 and overrun=0 next cycle.
- 1-cycle low glitch at mid-bit of a '1' data bit in 0xFF -> majority gives data=0xFF. rst_n pulsed mid-frame -> all outputs at reset values and no spurious byte afterwards.
